// File: rtl/integral_image_gen_if.sv
// Pixel stream in / integral write stream out for integral_image_gen.
// INT_SQ_DATA is present only when INTEGRAL_SQ_EN is defined.
interface integral_image_gen_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned SUM_W = 32
);
  logic             PIX_VALID;
  logic [PIX_W-1:0] PIX_DATA;
  logic             PIX_READY;
  logic             INT_VALID;
  logic [8:0]       INT_INDEX;
  logic [SUM_W-1:0] INT_DATA;
`ifdef INTEGRAL_SQ_EN
  logic [SUM_W-1:0] INT_SQ_DATA;

  modport master (
    output PIX_VALID, PIX_DATA,
    input  PIX_READY, INT_VALID, INT_INDEX, INT_DATA, INT_SQ_DATA
  );
  modport slave (
    input  PIX_VALID, PIX_DATA,
    output PIX_READY, INT_VALID, INT_INDEX, INT_DATA, INT_SQ_DATA
  );
`else
  modport master (
    output PIX_VALID, PIX_DATA,
    input  PIX_READY, INT_VALID, INT_INDEX, INT_DATA
  );
  modport slave (
    input  PIX_VALID, PIX_DATA,
    output PIX_READY, INT_VALID, INT_INDEX, INT_DATA
  );
`endif
endinterface

// File: rtl/integral_image_gen.sv
// Streaming integral-image generator over a WIDTH x HEIGHT raster window.
// Define INTEGRAL_SQ_EN to also produce the integral of squared pixels.
module integral_image_gen #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned HEIGHT = 20,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SUM_W  = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  integral_image_gen_if.slave bus,
  output logic                BUSY,
  output logic                DONE
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = $clog2(HEIGHT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             clear, accept, x_last, y_last;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [8:0]       idx_q;
  logic [SUM_W-1:0] rowsum_q, rowsum_base, rowsum_d, above, ii_d;
  logic [SUM_W-1:0] linebuf_q [WIDTH];
  logic             int_valid_q;
  logic [8:0]       int_index_q;
  logic [SUM_W-1:0] int_data_q;

  assign accept = (state_q == StRun) && bus.PIX_VALID;
  assign x_last = (x_q == XW'(WIDTH - 1));
  assign y_last = (y_q == YW'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d = StRun;
          clear   = 1'b1;
        end
      end
      StRun: begin
        if (accept && x_last && y_last) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Row accumulator restarts at column 0; the row above contributes nothing on row 0.
  always_comb begin
    rowsum_base = (x_q == '0) ? '0 : rowsum_q;
    above       = (y_q == '0) ? '0 : linebuf_q[x_q];
    rowsum_d    = rowsum_base + SUM_W'(bus.PIX_DATA);
    ii_d        = rowsum_d + above;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      rowsum_q    <= '0;
      int_valid_q <= 1'b0;
      int_index_q <= '0;
      int_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      int_valid_q <= accept;
      if (clear) begin
        x_q      <= '0;
        y_q      <= '0;
        idx_q    <= '0;
        rowsum_q <= '0;
      end else if (accept) begin
        rowsum_q    <= rowsum_d;
        int_index_q <= idx_q;
        int_data_q  <= ii_d;
        idx_q       <= idx_q + 9'd1;
        if (x_last) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // Holds the previous row's integral per column; no reset needed, START clears it.
  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int i = 0; i < int'(WIDTH); i++) linebuf_q[i] <= '0;
    end else if (accept) begin
      linebuf_q[x_q] <= ii_d;
    end
  end

`ifdef INTEGRAL_SQ_EN
  logic [SUM_W-1:0] sq_rowsum_q, sq_rowsum_base, sq_rowsum_d, sq_above, sq_ii_d, sq_pix;
  logic [SUM_W-1:0] sq_linebuf_q [WIDTH];
  logic [SUM_W-1:0] int_sq_data_q;

  always_comb begin
    sq_pix         = SUM_W'(bus.PIX_DATA) * SUM_W'(bus.PIX_DATA);
    sq_rowsum_base = (x_q == '0) ? '0 : sq_rowsum_q;
    sq_above       = (y_q == '0) ? '0 : sq_linebuf_q[x_q];
    sq_rowsum_d    = sq_rowsum_base + sq_pix;
    sq_ii_d        = sq_rowsum_d + sq_above;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sq_rowsum_q   <= '0;
      int_sq_data_q <= '0;
    end else if (clear) begin
      sq_rowsum_q <= '0;
    end else if (accept) begin
      sq_rowsum_q   <= sq_rowsum_d;
      int_sq_data_q <= sq_ii_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int i = 0; i < int'(WIDTH); i++) sq_linebuf_q[i] <= '0;
    end else if (accept) begin
      sq_linebuf_q[x_q] <= sq_ii_d;
    end
  end

  assign bus.INT_SQ_DATA = int_sq_data_q;
`endif

  assign bus.PIX_READY = (state_q == StRun);
  assign bus.INT_VALID = int_valid_q;
  assign bus.INT_INDEX = int_index_q;
  assign bus.INT_DATA  = int_data_q;
  assign BUSY          = (state_q == StRun);
  assign DONE          = (state_q == StDone);

endmodule

// File: tb/tb_integral_image_gen.sv
// Scoreboard bench for integral_image_gen: driver pushes model results on accept,
// a negedge monitor pops and compares each INT_VALID beat.
module tb_integral_image_gen;
  localparam int unsigned WIDTH  = 20;
  localparam int unsigned HEIGHT = 20;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SUM_W  = 32;
  localparam int          NPIX   = WIDTH * HEIGHT;

  logic CLK = 1'b0;
  logic RESET, START, BUSY, DONE;

  integral_image_gen_if #(.PIX_W(PIX_W), .SUM_W(SUM_W)) bus ();

  integral_image_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .PIX_W (PIX_W),
    .SUM_W (SUM_W)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .START(START),
    .bus  (bus),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int     idx;
    longint data;
    longint sq;
  } exp_t;

  exp_t exp_q[$];
  int   pix[NPIX];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Direct double sum over the stored frame, straight from the definition of II.
  function automatic longint model(input int x, input int y, input bit sq);
    longint s = 0;
    for (int j = 0; j <= y; j++) begin
      for (int i = 0; i <= x; i++) begin
        longint p = longint'(pix[j * WIDTH + i]);
        s += sq ? p * p : p;
      end
    end
    return s;
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (bus.INT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("int_index", longint'(bus.INT_INDEX), longint'(e.idx));
        check("int_data", longint'(bus.INT_DATA), e.data);
`ifdef INTEGRAL_SQ_EN
        check("int_sq_data", longint'(bus.INT_SQ_DATA), e.sq);
`endif
        check("done_with_beat", longint'(DONE), longint'(e.idx == NPIX - 1));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_int_valid"}, longint'(bus.INT_VALID), 0);
    check({tag, "_int_index"}, longint'(bus.INT_INDEX), 0);
    check({tag, "_int_data"}, longint'(bus.INT_DATA), 0);
    check({tag, "_pix_ready"}, longint'(bus.PIX_READY), 0);
    check({tag, "_busy"}, longint'(BUSY), 0);
    check({tag, "_done"}, longint'(DONE), 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    START = 1'b0;
    bus.PIX_VALID = 1'b0;
    bus.PIX_DATA  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    RESET = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("start_busy", longint'(BUSY), 1);
    check("start_done_low", longint'(DONE), 0);
    check("start_ready", longint'(bus.PIX_READY), 1);
  endtask

  // mode 0: constant val; mode 1: ramp x+y.
  task automatic run_frame(input int mode, input int val, input int gap_pct,
                           input int glitch_at, input int abort_at);
    int w;
    for (int k = 0; k < NPIX; k++) begin
      pix[k] = (mode == 0) ? val : (k % WIDTH) + (k / WIDTH);
    end
    for (int k = 0; k < NPIX; k++) begin
      if (k == abort_at) begin
        RESET = 1'b1;
        bus.PIX_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_outputs_zero("mid_reset");
        check("mid_reset_queue", longint'(exp_q.size()), 0);
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        bus.PIX_VALID = 1'b0;
        bus.PIX_DATA  = PIX_W'($urandom);
        @(posedge CLK);
        #1;
      end
      bus.PIX_VALID = 1'b1;
      bus.PIX_DATA  = PIX_W'(pix[k]);
      START = (k == glitch_at);
      w = 0;
      while (bus.PIX_READY !== 1'b1 && w < 8) begin
        @(posedge CLK);
        #1;
        w++;
      end
      if (w == 8) begin
        check("ready_timeout", 0, 1);
        bus.PIX_VALID = 1'b0;
        return;
      end
      @(posedge CLK);
      exp_q.push_back('{idx: k, data: model(k % WIDTH, k / WIDTH, 1'b0),
                        sq: model(k % WIDTH, k / WIDTH, 1'b1)});
      #1;
      START = 1'b0;
    end
    bus.PIX_VALID = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 10) begin
      @(posedge CLK);
      #1;
      w++;
    end
    check("drain_queue", longint'(exp_q.size()), 0);
    check("end_done", longint'(DONE), 1);
    check("end_busy", longint'(BUSY), 0);
    check("end_ready", longint'(bus.PIX_READY), 0);
    // Pixels offered after the frame must not produce beats.
    bus.PIX_VALID = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    bus.PIX_VALID = 1'b0;
    check("done_held", longint'(DONE), 1);
  endtask

  initial begin
    do_reset();

    pulse_start();
    run_frame(0, 1, 0, -1, -1);

    pulse_start();
    run_frame(0, 255, 0, -1, -1);

    pulse_start();
    run_frame(0, 2, 0, -1, -1);

    pulse_start();
    run_frame(1, 0, 30, 150, -1);

    pulse_start();
    run_frame(0, 1, 0, -1, 200);
    repeat (3) @(posedge CLK);
    #1;
    check("idle_after_reset_busy", longint'(BUSY), 0);
    check("idle_after_reset_ready", longint'(bus.PIX_READY), 0);

    pulse_start();
    run_frame(0, 1, 10, -1, -1);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/integral_image_gen.md
Name: integral_image_gen

Overview:
- Upstream feeder for the Avalon-MM integral buffer (words 0-399).
- Accepts a 20x20 pixel window streamed in raster order and computes the integral image II(x,y) = sum of p(x',y') over all x'<=x, y'<=y.
- Emits one (index, value) write per pixel into the buffer, and a sticky DONE level that mirrors into HW_DONE (word 510).
- Started by a pulse derived from SW_START (word 509).

Parameters:
- WIDTH, 20, window columns.
- HEIGHT, 20, window rows; WIDTH*HEIGHT must be <= 512.
- PIX_W, 8, pixel width, unsigned.
- SUM_W, 32, integral output width; must be >= PIX_W + clog2(WIDTH*HEIGHT).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  single-cycle start request
- PIX_VALID  in  1  pixel present on PIX_DATA
- PIX_DATA  in  PIX_W  unsigned pixel, raster order (x fastest)
- PIX_READY  out  1  block can accept a pixel this cycle
- INT_VALID  out  1  INT_INDEX/INT_DATA valid (write strobe to buffer)
- INT_INDEX  out  9  buffer word index = y*WIDTH + x
- INT_DATA  out  SUM_W  II(x,y), zero-extended
- BUSY  out  1  high in RUN
- DONE  out  1  sticky frame-complete level

Behaviour:
- Reset values: all outputs 0; state IDLE; x=0, y=0; row accumulator 0; line buffer contents don't-care (cleared on START).
- Clock and reset: CLK is the clock. RESET is synchronous, active-high, and overrides everything, including a mid-frame run. After RESET, the next frame requires a new START.
- States:
  - IDLE -> RUN on START. Clear x, y, the row accumulator and all WIDTH line-buffer entries (prev-row integral). DONE drops to 0.
  - RUN:
    - PIX_READY=1, BUSY=1.
    - A pixel is accepted when PIX_VALID && PIX_READY.
    - On accept: rowsum' = (x==0 ? 0 : rowsum) + p; II = rowsum' + (y==0 ? 0 : linebuf[x]); linebuf[x] <= II.
    - x increments. At x==WIDTH-1, x wraps to 0 and y increments.
    - Accepting the last pixel (x=WIDTH-1, y=HEIGHT-1) -> DONE state.
  - DONE: DONE=1 and held; PIX_READY=0; BUSY=0. START -> RUN (restart, same clearing as IDLE->RUN).
- Output timing:
  - INT_VALID/INT_INDEX/INT_DATA are registered, 1-cycle latency after the accepting edge.
  - INT_VALID is high exactly one cycle per accepted pixel.
  - Gaps in PIX_VALID produce gaps in INT_VALID. No pixel is dropped or duplicated.
- DONE rises in the same cycle that INT_VALID is presented for index WIDTH*HEIGHT-1.
- START while in RUN is ignored; the frame continues.
- PIX_VALID outside RUN is ignored; PIX_READY=0 there.
- Arithmetic is unsigned and cannot overflow under the SUM_W constraint. Maximum value at 20x20x255 is 102000.

Optional Feature:
- Macro: INTEGRAL_SQ_EN.
- With INTEGRAL_SQ_EN defined:
  - Extra output INT_SQ_DATA, out, SUM_W: the integral of p^2, for variance normalisation.
  - It uses its own row accumulator and WIDTH-entry line buffer.
  - It has the same timing and is valid with INT_VALID.
  - Maximum value is 400*65025 = 26010000.
- Without the macro: the port, accumulator and line buffer are absent. All other behaviour is identical.

Test Plan:
- All pixels = 1, no gaps, START pulse -> 400 INT_VALID beats, INT_DATA = (x+1)(y+1). Index 19 = 20, index 380 = 20, index 399 = 400. DONE high with index 399.
- All pixels = 255 -> index 0 = 255, index 399 = 102000. With INTEGRAL_SQ_EN, INT_SQ_DATA at index 399 = 26010000.
- Ramp p = x + y with random PIX_VALID gaps -> every INT_DATA matches a software integral model. Exactly 400 beats, indices 0..399 in order.
- START pulsed at pixel 150 while in RUN -> ignored. Output sequence is identical to the no-glitch run.
- RESET at pixel 200 -> all outputs 0 next cycle. A fresh START and all-1 frame gives index 0 = 1 (line buffer cleared, no stale data).
- After DONE, second START with all pixels = 2 -> DONE drops on START, index 399 = 800, DONE rises again.
